// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite constants and request type for the master arbiter
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam int PORT_FETCH = 0;
  localparam int PORT_LSU   = 1;

  localparam int AHB_AW = 32;
  localparam int AHB_DW = 32;

  // Canonical request bundle at the default bus widths.
  typedef struct packed {
    logic [AHB_AW-1:0] addr;
    logic              write;
    logic [AHB_DW-1:0] wdata;
  } ahb_req_t;

endpackage

// File: rtl/ahb_grant_sel.sv
// rtl/ahb_grant_sel.sv - two-port priority pick with fetch starvation guard
module ahb_grant_sel
  import ahb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          force_fetch;

  // Fetch has waited through LIMIT consecutive LSU grants: it takes this slot.
  assign force_fetch = req_i[PORT_FETCH] && (starve_q == LIMIT);

  // LSU wins by default; grant only when the address stage can accept.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (force_fetch)
        gnt_o[PORT_FETCH] = 1'b1;
      else if (req_i[PORT_LSU])
        gnt_o[PORT_LSU] = 1'b1;
      else if (req_i[PORT_FETCH])
        gnt_o[PORT_FETCH] = 1'b1;
    end
  end

  // Count LSU grants taken while fetch waits; any fetch grant or idle fetch clears.
  always_comb begin
    starve_d = starve_q;
    if (!req_i[PORT_FETCH] || gnt_o[PORT_FETCH])
      starve_d = '0;
    else if (gnt_o[PORT_LSU] && (starve_q != LIMIT))
      starve_d = starve_q + CW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst)
      starve_q <= '0;
    else
      starve_q <= starve_d;
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - shares one AHB-Lite master port between fetch and LSU
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int AW           = AHB_AW,
  parameter int DW           = AHB_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_i,
  input  logic [1:0][AW-1:0]   addr_i,
  input  logic [1:0]           write_i,
  input  logic [1:0][DW-1:0]   wdata_i,
  output logic [1:0]           gnt_o,
  output logic [1:0]           done_o,
  output logic                 err_o,
  output logic [DW-1:0]        rdata_o,
  output logic [AW-1:0]        HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [DW-1:0]        HWDATA,
  input  logic [DW-1:0]        HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
  } req_t;

  // Address stage: HADDR/HWRITE registers double as the stage's addr/write.
  logic          a_valid_q;
  logic          a_port_q;
  logic [DW-1:0] a_wdata_q;
  logic [AW-1:0] haddr_q;
  logic [1:0]    htrans_q;
  logic          hwrite_q;

  // Data stage: HWDATA register doubles as the stage's wdata.
  logic          d_valid_q;
  logic          d_port_q;
  logic          d_write_q;
  logic [DW-1:0] hwdata_q;

  // Completion reporting.
  logic [1:0]    done_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;

  logic          addr_free;
  logic          any_gnt;
  logic          sel_port;
  req_t          sel_req;

  // The address slot opens when empty or when its current phase is being accepted.
  assign addr_free = (!a_valid_q || HREADY) && !rst;

  ahb_grant_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_sel (
    .clk  (clk),
    .rst  (rst),
    .req_i(req_i),
    .en_i (addr_free),
    .gnt_o(gnt_o)
  );

  assign any_gnt  = |gnt_o;
  assign sel_port = gnt_o[PORT_LSU];

  // Route the granted port's request toward the address stage.
  always_comb begin
    sel_req       = '0;
    sel_req.addr  = addr_i[sel_port];
    sel_req.write = write_i[sel_port];
    sel_req.wdata = wdata_i[sel_port];
  end

  // Address stage: load on grant, drop to IDLE when the slot opens with nothing granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_port_q  <= 1'b0;
      a_wdata_q <= '0;
      haddr_q   <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
    end else if (addr_free) begin
      a_valid_q <= any_gnt;
      htrans_q  <= any_gnt ? HTRANS_NONSEQ : HTRANS_IDLE;
      if (any_gnt) begin
        a_port_q  <= sel_port;
        a_wdata_q <= sel_req.wdata;
        haddr_q   <= sel_req.addr;
        hwrite_q  <= sel_req.write;
      end
    end
  end

  // Data stage: advances from the address stage whenever the bus is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid_q <= 1'b0;
      d_port_q  <= 1'b0;
      d_write_q <= 1'b0;
      hwdata_q  <= '0;
    end else if (HREADY) begin
      d_valid_q <= a_valid_q;
      if (a_valid_q) begin
        d_port_q  <= a_port_q;
        d_write_q <= hwrite_q;
        hwdata_q  <= a_wdata_q;
      end
    end
  end

  // Completion pulse one cycle after the data phase ends; loads capture HRDATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= (d_valid_q && HREADY) ? (2'b01 << d_port_q) : 2'b00;
      err_q  <= d_valid_q && HREADY && HRESP;
      if (d_valid_q && HREADY && !d_write_q)
        rdata_q <= HRDATA;
    end
  end

  assign HADDR   = haddr_q;
  assign HTRANS  = htrans_q;
  assign HWRITE  = hwrite_q;
  assign HSIZE   = HSIZE_WORD;
  assign HWDATA  = hwdata_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - directed and randomized bench for ahb_master_arbiter
module tb_ahb_master_arbiter;
  import ahb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          req = 2'b00;
  logic [1:0][AW-1:0]  addr_v = '0;
  logic [1:0]          write_v = 2'b00;
  logic [1:0][DW-1:0]  wdata_v = '0;
  logic [1:0]          gnt_o, done_o;
  logic                err_o;
  logic [DW-1:0]       rdata_o;
  logic [AW-1:0]       HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [DW-1:0]       HWDATA;
  logic [DW-1:0]       HRDATA = '0;
  logic                HREADY = 1'b1;
  logic                HRESP = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wd;
  } txn_t;

  ahb_master_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr_v), .write_i(write_v), .wdata_i(wdata_v),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; HREADY = 1'b1; HRESP = 1'b0;
    step(); step();
    vec_cnt++; if (HTRANS !== HTRANS_IDLE) begin err_cnt++; $display("FAIL reset_htrans got=%b exp=%b", HTRANS, HTRANS_IDLE); end
    vec_cnt++; if (HADDR !== '0) begin err_cnt++; $display("FAIL reset_haddr got=%h exp=0", HADDR); end
    vec_cnt++; if (HWRITE !== 1'b0) begin err_cnt++; $display("FAIL reset_hwrite got=%b exp=0", HWRITE); end
    vec_cnt++; if (HWDATA !== '0) begin err_cnt++; $display("FAIL reset_hwdata got=%h exp=0", HWDATA); end
    vec_cnt++; if (gnt_o !== 2'b00) begin err_cnt++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
    vec_cnt++; if (done_o !== 2'b00) begin err_cnt++; $display("FAIL reset_done got=%b exp=00", done_o); end
    vec_cnt++; if (err_o !== 1'b0) begin err_cnt++; $display("FAIL reset_err got=%b exp=0", err_o); end
    vec_cnt++; if (rdata_o !== '0) begin err_cnt++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    vec_cnt++; if (HSIZE !== 3'b010) begin err_cnt++; $display("FAIL hsize got=%b exp=010", HSIZE); end
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    req = 2'b10; addr_v[1] = 32'h100; write_v[1] = 1'b0; HREADY = 1'b1; HRDATA = 32'hDEADBEEF;
    #1;
    vec_cnt++; if (gnt_o !== 2'b10) begin err_cnt++; $display("FAIL t1_gnt got=%b exp=10", gnt_o); end
    step(); req = 2'b00;
    vec_cnt++; if (HTRANS !== HTRANS_NONSEQ) begin err_cnt++; $display("FAIL t1_htrans got=%b exp=10", HTRANS); end
    vec_cnt++; if (HADDR !== 32'h100) begin err_cnt++; $display("FAIL t1_haddr got=%h exp=100", HADDR); end
    step();
    vec_cnt++; if (done_o !== 2'b00) begin err_cnt++; $display("FAIL t1_done_early got=%b exp=00", done_o); end
    step();
    vec_cnt++; if (done_o !== 2'b10) begin err_cnt++; $display("FAIL t1_done got=%b exp=10", done_o); end
    vec_cnt++; if (rdata_o !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL t1_rdata got=%h exp=deadbeef", rdata_o); end
    vec_cnt++; if (err_o !== 1'b0) begin err_cnt++; $display("FAIL t1_err got=%b exp=0", err_o); end
    step();
    vec_cnt++; if (done_o !== 2'b00) begin err_cnt++; $display("FAIL t1_done_pulse got=%b exp=00", done_o); end
  endtask

  task automatic test_store_wait();
    req = 2'b01; addr_v[0] = 32'h40; write_v[0] = 1'b1; wdata_v[0] = 32'h5A5A; HREADY = 1'b1;
    HRDATA = 32'h1111_2222;
    #1;
    vec_cnt++; if (gnt_o !== 2'b01) begin err_cnt++; $display("FAIL t2_gnt got=%b exp=01", gnt_o); end
    step(); req = 2'b00;
    vec_cnt++; if (HTRANS !== HTRANS_NONSEQ || HADDR !== 32'h40 || HWRITE !== 1'b1) begin
      err_cnt++; $display("FAIL t2_addr_phase got=%b/%h/%b exp=10/40/1", HTRANS, HADDR, HWRITE);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if (HWDATA !== 32'h5A5A) begin err_cnt++; $display("FAIL t2_hwdata[%0d] got=%h exp=5a5a", i, HWDATA); end
      vec_cnt++; if (done_o !== 2'b00) begin err_cnt++; $display("FAIL t2_done_wait[%0d] got=%b exp=00", i, done_o); end
      HREADY = (i == 2);
      step();
    end
    vec_cnt++; if (done_o !== 2'b01) begin err_cnt++; $display("FAIL t2_done got=%b exp=01", done_o); end
    vec_cnt++; if (rdata_o !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL t2_rdata_kept got=%h exp=deadbeef", rdata_o); end
    write_v[0] = 1'b0;
  endtask

  task automatic test_starvation();
    int exp_port [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [1:0] exp_g;
    req = 2'b11; write_v = 2'b00; HREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr_v[0] = AW'(i * 4);
      addr_v[1] = AW'(32'h1000 + i * 4);
      #1;
      exp_g = 2'b01 << exp_port[i];
      vec_cnt++; if (gnt_o !== exp_g) begin err_cnt++; $display("FAIL t3_gnt[%0d] got=%b exp=%b", i, gnt_o, exp_g); end
      step();
    end
    req = 2'b00;
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin req = 2'b10; addr_v[1] = AW'(i * 4); end
      else req = 2'b00;
      if (i >= 1 && i <= 3) begin
        vec_cnt++; if (HTRANS !== HTRANS_NONSEQ || HADDR !== AW'((i - 1) * 4)) begin
          err_cnt++; $display("FAIL t4_addr[%0d] got=%b/%h exp=10/%h", i, HTRANS, HADDR, (i - 1) * 4);
        end
      end
      if (i >= 3) begin
        vec_cnt++; if (done_o !== 2'b10 || rdata_o !== DW'(32'h1000 + (i - 3) * 4)) begin
          err_cnt++; $display("FAIL t4_done[%0d] got=%b/%h exp=10/%h", i, done_o, rdata_o, 32'h1000 + (i - 3) * 4);
        end
      end
      if (i >= 2) HRDATA = DW'(32'h1000 + (i - 2) * 4);
      if (i < 3) begin
        #1;
        vec_cnt++; if (gnt_o !== 2'b10) begin err_cnt++; $display("FAIL t4_gnt[%0d] got=%b exp=10", i, gnt_o); end
      end
      step();
    end
    vec_cnt++; if (done_o !== 2'b00) begin err_cnt++; $display("FAIL t4_done_end got=%b exp=00", done_o); end
  endtask

  task automatic test_error();
    req = 2'b10; addr_v[1] = 32'h200; write_v[1] = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    #1;
    vec_cnt++; if (gnt_o !== 2'b10) begin err_cnt++; $display("FAIL t5_gnt0 got=%b exp=10", gnt_o); end
    step(); addr_v[1] = 32'h204;
    #1;
    vec_cnt++; if (gnt_o !== 2'b10) begin err_cnt++; $display("FAIL t5_gnt1 got=%b exp=10", gnt_o); end
    step(); req = 2'b00; HREADY = 1'b0; HRESP = 1'b1;
    vec_cnt++; if (HTRANS !== HTRANS_NONSEQ || HADDR !== 32'h204) begin err_cnt++; $display("FAIL t5_pipe got=%b/%h exp=10/204", HTRANS, HADDR); end
    step(); HREADY = 1'b1; HRESP = 1'b1;
    vec_cnt++; if (HADDR !== 32'h204 || done_o !== 2'b00) begin err_cnt++; $display("FAIL t5_wait got=%h/%b exp=204/00", HADDR, done_o); end
    step(); HRESP = 1'b0; HRDATA = 32'hA5A50204;
    vec_cnt++; if (done_o !== 2'b10 || err_o !== 1'b1) begin err_cnt++; $display("FAIL t5_err_done got=%b/%b exp=10/1", done_o, err_o); end
    vec_cnt++; if (HTRANS !== HTRANS_IDLE) begin err_cnt++; $display("FAIL t5_idle got=%b exp=00", HTRANS); end
    step();
    vec_cnt++; if (done_o !== 2'b10 || err_o !== 1'b0 || rdata_o !== 32'hA5A50204) begin
      err_cnt++; $display("FAIL t5_ok_done got=%b/%b/%h exp=10/0/a5a50204", done_o, err_o, rdata_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req = 2'b01; addr_v[0] = 32'h300; write_v[0] = 1'b0; HREADY = 1'b1;
    #1;
    vec_cnt++; if (gnt_o !== 2'b01) begin err_cnt++; $display("FAIL t6_gnt got=%b exp=01", gnt_o); end
    step(); req = 2'b00;
    step(); HREADY = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0; HREADY = 1'b1;
    vec_cnt++; if (HTRANS !== HTRANS_IDLE) begin err_cnt++; $display("FAIL t6_htrans got=%b exp=00", HTRANS); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (done_o !== 2'b00) begin err_cnt++; $display("FAIL t6_done[%0d] got=%b exp=00", i, done_o); end
      step();
    end
  endtask

  task automatic test_random(input int cycles);
    txn_t aq[$], dq[$], t;
    logic [1:0]    exp_htrans = HTRANS_IDLE, exp_done = 2'b00, exp_gnt, gnt_prev = 2'b00;
    logic [AW-1:0] exp_haddr = '0;
    logic [DW-1:0] exp_hwdata = '0, exp_rdata = '0;
    logic          exp_hwrite = 1'b0, exp_err = 1'b0, free;
    int            starve = 0, g;
    rst = 1'b1; req = 2'b00; HREADY = 1'b1; HRESP = 1'b0;
    step();
    rst = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      vec_cnt++; if (HTRANS !== exp_htrans) begin err_cnt++; $display("FAIL rnd_htrans[%0d] got=%b exp=%b", n, HTRANS, exp_htrans); end
      vec_cnt++; if (HADDR !== exp_haddr) begin err_cnt++; $display("FAIL rnd_haddr[%0d] got=%h exp=%h", n, HADDR, exp_haddr); end
      vec_cnt++; if (HWRITE !== exp_hwrite) begin err_cnt++; $display("FAIL rnd_hwrite[%0d] got=%b exp=%b", n, HWRITE, exp_hwrite); end
      vec_cnt++; if (HWDATA !== exp_hwdata) begin err_cnt++; $display("FAIL rnd_hwdata[%0d] got=%h exp=%h", n, HWDATA, exp_hwdata); end
      vec_cnt++; if (done_o !== exp_done || err_o !== exp_err) begin
        err_cnt++; $display("FAIL rnd_done[%0d] got=%b/%b exp=%b/%b", n, done_o, err_o, exp_done, exp_err);
      end
      vec_cnt++; if (rdata_o !== exp_rdata) begin err_cnt++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", n, rdata_o, exp_rdata); end
      for (int p = 0; p < 2; p++) begin
        if (req[p] && gnt_prev[p]) req[p] = 1'b0;
        if (!req[p] && $urandom_range(0, 2) == 0) begin
          req[p]     = 1'b1;
          addr_v[p]  = AW'($urandom_range(0, 255)) << 2;
          write_v[p] = 1'($urandom_range(0, 1));
          wdata_v[p] = DW'($urandom);
        end
      end
      HREADY = ($urandom_range(0, 3) != 0);
      HRESP  = HREADY && ($urandom_range(0, 7) == 0);
      HRDATA = DW'($urandom);
      #1;
      free = (aq.size() == 0) || HREADY;
      g = -1;
      if (free && req != 2'b00) begin
        if (req[0] && starve == LIM) g = 0;
        else if (req[1]) g = 1;
        else g = 0;
      end
      exp_gnt = (g < 0) ? 2'b00 : (2'b01 << g);
      vec_cnt++; if (gnt_o !== exp_gnt) begin err_cnt++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", n, gnt_o, exp_gnt); end
      gnt_prev = gnt_o;
      exp_done = 2'b00; exp_err = 1'b0;
      if (HREADY && dq.size() != 0) begin
        t = dq.pop_front();
        exp_done = 2'b01 << t.port;
        exp_err  = HRESP;
        if (!t.wr) exp_rdata = HRDATA;
      end
      if (HREADY && aq.size() != 0) begin
        t = aq.pop_front();
        exp_hwdata = t.wd;
        dq.push_back(t);
      end
      if (free) begin
        if (g >= 0) begin
          t.port = g; t.addr = addr_v[g]; t.wr = write_v[g]; t.wd = wdata_v[g];
          aq.push_back(t);
          exp_htrans = HTRANS_NONSEQ; exp_haddr = t.addr; exp_hwrite = t.wr;
        end else begin
          exp_htrans = HTRANS_IDLE;
        end
      end
      if (g == 1 && req[0]) starve = (starve < LIM) ? starve + 1 : LIM;
      else if (g == 0 || !req[0]) starve = 0;
      step();
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_store_wait();
    test_starvation();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
